baud_switch_ctrl: RTL and testbench

Runtime baud-rate switch controller that sequences the `Baudrate` prescaler bank. It accepts a new baud select over a valid/ready handshake and pauses the UART TX/RX engines. It waits for both engines to go idle, then drives the new `Prescaler_sel`. It signals completion once the selected `Uart_clk` has produced a programmable number of rising edges. It sits between the host/config path and `Baudrate`, and is the only driver of `Prescaler_sel`.

---
 rtl/baud_switch_ctrl_pkg.sv | 26 ++
 rtl/baud_switch_ctrl_if.sv | 27 ++
 rtl/baud_edge_counter.sv | 43 ++++
 rtl/baud_switch_ctrl.sv | 149 ++++++++++++++
 tb/tb_baud_switch_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_switch_ctrl_pkg.sv
// Shared codes for the baud switch controller: prescaler select values,
// FSM state encoding and edge counter width.
package baud_switch_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_9600     = 2'b00,
        SEL_57600    = 2'b01,
        SEL_115200   = 2'b10,
        SEL_RESERVED = 2'b11
    } baud_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE,
        ST_DONE
    } switch_state_t;

    localparam int unsigned EDGE_CNT_W = 4;

    function automatic logic is_reserved(input logic [1:0] sel);
        return sel == SEL_RESERVED;
    endfunction

endpackage

// File: rtl/baud_switch_ctrl_if.sv
// Request/response handshake between the host config path and the baud
// switch controller.
interface baud_switch_ctrl_if;

    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       done;
    logic       err;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready,
        output done,
        output err
    );

endinterface

// File: rtl/baud_edge_counter.sv
// Registers uart_clk, flags its rising edges and keeps a saturating count
// of them while enabled; a synchronous clear wipes both count and history.
module baud_edge_counter
    import baud_switch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  uart_clk,
    output logic                  rise,
    output logic [EDGE_CNT_W-1:0] count
);

    logic                  uart_clk_q, uart_clk_d;
    logic [EDGE_CNT_W-1:0] count_q, count_d;

    assign rise  = uart_clk & ~uart_clk_q;
    assign count = count_q;

    // Clearing history to 0 means a uart_clk already high counts as a rise.
    always_comb begin
        uart_clk_d = uart_clk;
        count_d    = count_q;
        if (clear) begin
            uart_clk_d = 1'b0;
            count_d    = '0;
        end else if (enable && rise && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_clk_q <= 1'b0;
            count_q    <= '0;
        end else begin
            uart_clk_q <= uart_clk_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/baud_switch_ctrl.sv
// Runtime baud-rate switch sequencer: pauses the UART engines, waits for idle,
// loads the new prescaler select and waits for uart_clk to settle.
// Optional DRAIN timeout enabled by defining BAUD_SWITCH_TIMEOUT_EN.
module baud_switch_ctrl
    import baud_switch_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_EDGES   = 2,
    parameter logic [1:0]  SEL_RESET      = SEL_9600
`ifdef BAUD_SWITCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                     src_clk,
    input  logic                     rst_n,
    baud_switch_ctrl_if.slave        req_if,
    input  logic                     tx_busy,
    input  logic                     rx_busy,
    input  logic                     uart_clk,
    output logic                     pause,
    output logic [1:0]               prescaler_sel
);

    switch_state_t         state_q, state_d;
    logic [1:0]            pending_sel_q, pending_sel_d;
    logic [1:0]            prescaler_sel_q, prescaler_sel_d;
    logic                  pause_q, pause_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cnt_clear;
    logic                  edge_rise;
    logic [EDGE_CNT_W-1:0] edge_count;
    logic                  settle_hit;
`ifdef BAUD_SWITCH_TIMEOUT_EN
    logic [15:0]           drain_cnt_q, drain_cnt_d;
`endif

    baud_edge_counter u_edge_counter (
        .clk      (src_clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (state_q == ST_SETTLE),
        .uart_clk (uart_clk),
        .rise     (edge_rise),
        .count    (edge_count)
    );

    // Look at the rise in flight so done follows the final rise by one cycle.
    assign settle_hit = (SETTLE_EDGES == 0) ||
                        (edge_rise && (({1'b0, edge_count} + 5'd1) == 5'(SETTLE_EDGES)));

    assign req_if.req_ready = (state_q == ST_IDLE);
    assign req_if.done      = done_q;
    assign req_if.err       = err_q;
    assign pause            = pause_q;
    assign prescaler_sel    = prescaler_sel_q;

    always_comb begin
        state_d         = state_q;
        pending_sel_d   = pending_sel_q;
        prescaler_sel_d = prescaler_sel_q;
        pause_d         = pause_q;
        done_d          = 1'b0;
        err_d           = 1'b0;
        cnt_clear       = 1'b0;
`ifdef BAUD_SWITCH_TIMEOUT_EN
        drain_cnt_d     = drain_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    if (is_reserved(req_if.req_sel)) begin
                        err_d = 1'b1;
                    end else if (req_if.req_sel == prescaler_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_sel_d = req_if.req_sel;
                        pause_d       = 1'b1;
                        state_d       = ST_DRAIN;
`ifdef BAUD_SWITCH_TIMEOUT_EN
                        drain_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                if (!tx_busy && !rx_busy) begin
                    state_d = ST_SWITCH;
`ifdef BAUD_SWITCH_TIMEOUT_EN
                end else if (drain_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 16'd1;
`endif
                end
            end
            ST_SWITCH: begin
                prescaler_sel_d = pending_sel_q;
                cnt_clear       = 1'b1;
                state_d         = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_hit) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                pause_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                pause_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            pending_sel_q   <= SEL_RESET;
            prescaler_sel_q <= SEL_RESET;
            pause_q         <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_sel_q   <= pending_sel_d;
            prescaler_sel_q <= prescaler_sel_d;
            pause_q         <= pause_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

`ifdef BAUD_SWITCH_TIMEOUT_EN
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_baud_switch_ctrl.sv
// Self-checking bench for baud_switch_ctrl: randomized requests against a
// timeline model of the switch sequence (edge offsets from acceptance).
module tb_baud_switch_ctrl;

    localparam int unsigned SETTLE = 2;

    logic       src_clk;
    logic       rst_n;
    logic       tx_busy;
    logic       rx_busy;
    logic       uart_clk;
    logic       pause;
    logic [1:0] prescaler_sel;
    logic [1:0] exp_sel;
    int         checks;
    int         failures;

    baud_switch_ctrl_if bus ();

    baud_switch_ctrl #(
        .SETTLE_EDGES   (SETTLE),
        .SEL_RESET      (2'b00)
`ifdef BAUD_SWITCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .src_clk       (src_clk),
        .rst_n         (rst_n),
        .req_if        (bus.slave),
        .tx_busy       (tx_busy),
        .rx_busy       (rx_busy),
        .uart_clk      (uart_clk),
        .pause         (pause),
        .prescaler_sel (prescaler_sel)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic e_pause, input logic e_ready,
                              input logic [1:0] e_sel, input logic e_done, input logic e_err);
        checkOutput({tag, ".pause"}, 32'(pause), 32'(e_pause));
        checkOutput({tag, ".ready"}, 32'(bus.req_ready), 32'(e_ready));
        checkOutput({tag, ".sel"}, 32'(prescaler_sel), 32'(e_sel));
        checkOutput({tag, ".done"}, 32'(bus.done), 32'(e_done));
        checkOutput({tag, ".err"}, 32'(bus.err), 32'(e_err));
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid = 1'b0;
            tx_busy  = 1'($urandom_range(0, 1));
            rx_busy  = 1'($urandom_range(0, 1));
            uart_clk = 1'($urandom_range(0, 1));
            tick();
            checkState("idle", 1'b0, 1'b1, exp_sel, 1'b0, 1'b0);
        end
    endtask

    // One request; t counts edges after the acceptance edge (t = 0).
    task automatic applyStimulus(input logic [1:0] s, input int txl, input int rxl);
        logic [1:0] old_sel;
        int         ld;
        int         e;
        int         rises;
        logic       prev_u;
        logic       last_u;
        logic       rise;
        bit         finished;
        old_sel = exp_sel;
        bus.req_valid = 1'b1;
        bus.req_sel   = s;
        tx_busy  = 1'($urandom_range(0, 1));
        rx_busy  = 1'($urandom_range(0, 1));
        uart_clk = 1'($urandom_range(0, 1));
        last_u   = uart_clk;
        tick();
        if (s == 2'b11) begin
            checkState("rsv_t0", 1'b0, 1'b1, old_sel, 1'b0, 1'b1);
            bus.req_valid = 1'b0;
            tick();
            checkState("rsv_t1", 1'b0, 1'b1, old_sel, 1'b0, 1'b0);
            return;
        end
        if (s == old_sel) begin
            checkState("same_t0", 1'b0, 1'b1, old_sel, 1'b1, 1'b0);
            bus.req_valid = 1'b0;
            tick();
            checkState("same_t1", 1'b0, 1'b1, old_sel, 1'b0, 1'b0);
            return;
        end
        // Busy low is first sampled at edge 1+max(len); the select lands one edge later.
        ld       = 2 + ((txl > rxl) ? txl : rxl);
        e        = -1;
        rises    = 0;
        prev_u   = 1'b0;
        finished = 1'b0;
        for (int t = 0; t < 600; t++) begin
            if (t >= ld + 1 && e < 0) begin
                rise   = last_u & ~prev_u;
                prev_u = last_u;
                if (rise) rises++;
                if (rises >= int'(SETTLE)) e = t;
            end
            if (e >= 0 && t == e + 1) begin
                checkState("sw_end", 1'b0, 1'b1, s, 1'b0, 1'b0);
                finished = 1'b1;
                break;
            end
            checkState("sw_run", 1'b1, 1'b0, (t >= ld) ? s : old_sel, 1'(t == e), 1'b0);
            tx_busy  = (t < ld - 1) ? 1'(t < txl) : 1'($urandom_range(0, 1));
            rx_busy  = (t < ld - 1) ? 1'(t < rxl) : 1'($urandom_range(0, 1));
            uart_clk = 1'($urandom_range(0, 1));
            last_u   = uart_clk;
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_sel   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.req_valid = 1'b0;
        checkOutput("sw_complete", 32'(finished), 32'd1);
        exp_sel = s;
    endtask

    task automatic applyStuckDrain();
        logic [1:0] s;
        logic [1:0] old_sel;
        old_sel = exp_sel;
        s = (exp_sel == 2'b01) ? 2'b10 : 2'b01;
        bus.req_valid = 1'b1;
        bus.req_sel   = s;
        tx_busy = 1'b0;
        rx_busy = 1'b1;
        tick();
        bus.req_valid = 1'b0;
`ifdef BAUD_SWITCH_TIMEOUT_EN
        for (int t = 0; t <= 101; t++) begin
            if (t < 100)       checkState("tmo_wait", 1'b1, 1'b0, old_sel, 1'b0, 1'b0);
            else if (t == 100) checkState("tmo_err", 1'b0, 1'b1, old_sel, 1'b0, 1'b1);
            else               checkState("tmo_after", 1'b0, 1'b1, old_sel, 1'b0, 1'b0);
            if (t < 101) tick();
        end
`else
        for (int t = 0; t < 1000; t++) begin
            checkState("drain_hold", 1'b1, 1'b0, old_sel, 1'b0, 1'b0);
            tick();
        end
        checkState("drain_1000", 1'b1, 1'b0, old_sel, 1'b0, 1'b0);
`endif
        rx_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_sel = 2'b00;
        checkState("stuck_rst", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic applyMidSettleReset();
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b10;
        tx_busy  = 1'b0;
        rx_busy  = 1'b0;
        uart_clk = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        checkState("mid_t0", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        checkState("mid_t1", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        checkState("mid_t2", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        checkState("mid_t3", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkState("mid_rst", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        exp_sel = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            uart_clk = ~uart_clk;
            tick();
            checkState("post_rst", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        tx_busy       = 1'b0;
        rx_busy       = 1'b0;
        uart_clk      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_sel   = 2'b00;
        exp_sel       = 2'b00;
        repeat (3) @(posedge src_clk);
        #1;
        checkState("reset", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        checkState("post_reset", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        applyStimulus(2'b10, 0, 0);
        idleCycles(2);
        applyStimulus(2'b11, 0, 0);
        applyStimulus(exp_sel, 0, 0);
        idleCycles(1);
        applyStimulus(2'b01, 50, 0);
        applyStimulus(2'b00, 3, 7);

        for (int n = 0; n < 30; n++) begin
            idleCycles(int'($urandom_range(0, 3)));
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                          int'($urandom_range(0, 12)));
        end

        idleCycles(2);
        applyStuckDrain();
        idleCycles(2);
        applyMidSettleReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
